// File: rtl/csidh_pkg.sv
// csidh_pkg
//  Shared constants for the CSIDH-512 host loader: the prime p, request frame
//  geometry, response status codes, loader state encoding and the modes of the
//  per-word input checker.
package csidh_pkg;

    localparam int N_BITS     = 512;
    localparam int NUM_PRIMES = 74;
    localparam int AW         = N_BITS / 64;   // A words in a request
    localparam int PW         = 5;             // packed exponent words in a request

    // Exponent nibbles that live in the final (partial) exponent word.
    localparam int LAST_NIBBLES = NUM_PRIMES - (PW - 1) * 16;

    localparam logic [3:0] LAST_WORD = 4'(AW + PW - 1);

    // CSIDH-512 prime, 4 * (3 * 5 * ... * 373) * 587 - 1.
    localparam logic [511:0] P =
        512'h65b48e8f740f89bf_fc8ab0d15e3e4c4a_b42d083aedc88c42_5afbfcc69322c9cd_a7aac6c567f35507_516730cc1f0b4f25_c2721bf457aca835_1b81b90533c6c87b;

    localparam logic [2:0] STATUS_OK      = 3'd0;
    localparam logic [2:0] STATUS_RANGE   = 3'd1;
    localparam logic [2:0] STATUS_EXP     = 3'd2;
    localparam logic [2:0] STATUS_INVALID = 3'd3;
    localparam logic [2:0] STATUS_FRAME   = 3'd4;
    localparam logic [2:0] STATUS_TIMEOUT = 3'd5;

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_HDR   = 3'd4;
    localparam logic [2:0] S_DATA  = 3'd5;

    localparam logic [1:0] MODE_A        = 2'd0;
    localparam logic [1:0] MODE_EXP      = 2'd1;
    localparam logic [1:0] MODE_EXP_LAST = 2'd2;

endpackage

// File: rtl/csidh_word_check.sv
// csidh_word_check
//  Combinational check of one 64-bit request word.
//  Ports:
//   word     in   64  request word under test
//   p_word   in   64  matching 64-bit slice of p (used in MODE_A)
//   mode     in   2   MODE_A, MODE_EXP or MODE_EXP_LAST
//   lt, gt   out  1   word < p_word, word > p_word
//   exp_err  out  1   word holds an illegal exponent nibble or nonzero padding
module csidh_word_check
    import csidh_pkg::*;
#(
    parameter int MAX_EXP = 5
) (
    input  logic [63:0] word,
    input  logic [63:0] p_word,
    input  logic [1:0]  mode,
    output logic        lt,
    output logic        gt,
    output logic        exp_err
);

    // 4'b1000 (-8) is rejected explicitly even if MAX_EXP were ever raised to 8.
    function automatic logic nibble_bad(input logic [3:0] nib);
        int v;
        v = nib[3] ? int'(nib) - 16 : int'(nib);
        return (nib == 4'b1000) || (v > MAX_EXP) || (v < -MAX_EXP);
    endfunction

    always_comb begin
        lt      = word < p_word;
        gt      = word > p_word;
        exp_err = 1'b0;
        if (mode != MODE_A) begin
            for (int i = 0; i < 16; i++) begin
                if ((mode == MODE_EXP || i < LAST_NIBBLES) && nibble_bad(word[4*i +: 4])) begin
                    exp_err = 1'b1;
                end
            end
            // Padding above the last exponent must be zero.
            if (mode == MODE_EXP_LAST && word[63:4*LAST_NIBBLES] != '0) begin
                exp_err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csidh_host_loader.sv
// csidh_host_loader
//  Framing / validation front end for the CSIDH-512 group-action core. Loads
//  one request (8 A words, 5 exponent words, LSW first), rejects bad input,
//  runs the core with a watchdog and streams back a status header plus,
//  on success, the 8 result words.
//  Ports:
//   clk, rst                               clock, async active-high reset
//   in_data/in_valid/in_last/in_ready      request stream
//   out_data/out_valid/out_last/out_ready  response stream
//   core_rst                               1 holds the core in reset
//   core_A_in, core_private                operands to the core
//   core_A_out, core_done, core_invalid    core result and completion
module csidh_host_loader
    import csidh_pkg::*;
#(
    parameter int N          = 512,
    parameter int NUM_PRIMES = 74,
    parameter int MAX_EXP    = 5,
    parameter int TIMEOUT    = 2**30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [63:0]             in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [63:0]             out_data,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    core_rst,
    output logic [N-1:0]            core_A_in,
    output logic [4*NUM_PRIMES-1:0] core_private,
    input  logic [N-1:0]            core_A_out,
    input  logic                    core_done,
    input  logic                    core_invalid
);

    localparam int PRIV_W = 4 * NUM_PRIMES;
    localparam int PLO    = (PW - 1) * 64;

    logic [2:0]        state_q, state_d;
    logic [3:0]        word_cnt_q, word_cnt_d;
    logic              lt_q, lt_d;
    logic              err_exp_q, err_exp_d;
    logic [N-1:0]      a_q, a_d;
    logic [PRIV_W-1:0] priv_q, priv_d;
    logic [N-1:0]      res_q, res_d;
    logic [2:0]        status_q, status_d;
    logic              core_rst_q, core_rst_d;
    logic [31:0]       run_cnt_q, run_cnt_d;
    logic              armed_q, armed_d;

    logic       chk_lt, chk_gt, chk_exp_err;
    logic [1:0] chk_mode;
    logic       in_fire, out_fire;

    assign chk_mode = (word_cnt_q < 4'(AW))    ? MODE_A :
                      (word_cnt_q == LAST_WORD) ? MODE_EXP_LAST : MODE_EXP;

    csidh_word_check #(.MAX_EXP(MAX_EXP)) u_check (
        .word    (in_data),
        .p_word  (P[{word_cnt_q[2:0], 6'b0} +: 64]),
        .mode    (chk_mode),
        .lt      (chk_lt),
        .gt      (chk_gt),
        .exp_err (chk_exp_err)
    );

    // armed_q keeps in_ready low for the first cycle out of reset.
    assign in_ready  = armed_q && (state_q == S_LOAD || state_q == S_DRAIN);
    assign out_valid = (state_q == S_HDR) || (state_q == S_DATA);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (state_q == S_HDR) begin
            out_data = {61'b0, status_q};
            out_last = status_q != STATUS_OK;
        end else if (state_q == S_DATA) begin
            out_data = res_q[{word_cnt_q[2:0], 6'b0} +: 64];
            out_last = word_cnt_q == 4'(AW - 1);
        end
    end

    assign core_rst     = core_rst_q;
    assign core_A_in    = a_q;
    assign core_private = priv_q;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        lt_d       = lt_q;
        err_exp_d  = err_exp_q;
        a_d        = a_q;
        priv_d     = priv_q;
        res_d      = res_q;
        status_d   = status_q;
        core_rst_d = core_rst_q;
        run_cnt_d  = run_cnt_q;
        armed_d    = 1'b1;

        case (state_q)
            S_LOAD: begin
                if (in_fire) begin
                    word_cnt_d = word_cnt_q + 4'd1;
                    if (word_cnt_q < 4'(AW)) begin
                        // Serial LSW-first compare: a higher word overrides lower ones.
                        a_d[{word_cnt_q[2:0], 6'b0} +: 64] = in_data;
                        lt_d = chk_lt ? 1'b1 :
                               chk_gt ? 1'b0 :
                               (word_cnt_q == 4'd0) ? 1'b0 : lt_q;
                        if (word_cnt_q == 4'd0) begin
                            err_exp_d = 1'b0;
                        end
                    end else begin
                        if (word_cnt_q == LAST_WORD) begin
                            priv_d[PRIV_W-1:PLO] = in_data[PRIV_W-PLO-1:0];
                        end else begin
                            priv_d[{word_cnt_q[1:0], 6'b0} +: 64] = in_data;
                        end
                        err_exp_d = err_exp_q | chk_exp_err;
                    end

                    if (in_last) begin
                        word_cnt_d = 4'd0;
                        if (word_cnt_q == LAST_WORD) begin
                            state_d = S_CHECK;
                        end else begin
                            status_d = STATUS_FRAME;
                            state_d  = S_HDR;
                        end
                    end else if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = 4'd0;
                        status_d   = STATUS_FRAME;
                        state_d    = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (in_fire && in_last) begin
                    state_d = S_HDR;
                end
            end

            S_CHECK: begin
                if (!lt_q) begin
                    status_d = STATUS_RANGE;
                    state_d  = S_HDR;
                end else if (err_exp_q) begin
                    status_d = STATUS_EXP;
                    state_d  = S_HDR;
                end else begin
                    core_rst_d = 1'b0;
                    run_cnt_d  = '0;
                    state_d    = S_RUN;
                end
            end

            S_RUN: begin
                // core_done is tested first so it wins over a coincident timeout.
                if (core_done) begin
                    res_d      = core_A_out;
                    core_rst_d = 1'b1;
                    status_d   = core_invalid ? STATUS_INVALID : STATUS_OK;
                    state_d    = S_HDR;
                end else if (run_cnt_q == 32'(TIMEOUT - 1)) begin
                    core_rst_d = 1'b1;
                    status_d   = STATUS_TIMEOUT;
                    state_d    = S_HDR;
                end else begin
                    run_cnt_d = run_cnt_q + 32'd1;
                end
            end

            S_HDR: begin
                if (out_fire) begin
                    state_d = (status_q == STATUS_OK) ? S_DATA : S_LOAD;
                end
            end

            S_DATA: begin
                if (out_fire) begin
                    if (word_cnt_q == 4'(AW - 1)) begin
                        word_cnt_d = 4'd0;
                        state_d    = S_LOAD;
                    end else begin
                        word_cnt_d = word_cnt_q + 4'd1;
                    end
                end
            end

            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            word_cnt_q <= '0;
            lt_q       <= 1'b0;
            err_exp_q  <= 1'b0;
            a_q        <= '0;
            priv_q     <= '0;
            res_q      <= '0;
            status_q   <= '0;
            core_rst_q <= 1'b1;
            run_cnt_q  <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            lt_q       <= lt_d;
            err_exp_q  <= err_exp_d;
            a_q        <= a_d;
            priv_q     <= priv_d;
            res_q      <= res_d;
            status_q   <= status_d;
            core_rst_q <= core_rst_d;
            run_cnt_q  <= run_cnt_d;
            armed_q    <= armed_d;
        end
    end

endmodule
